// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of an asynchronous 16-bit SRAM.
// Each grant runs IDLE -> ACCESS (ACCESS_CYCLES strobe cycles) -> DONE (one-cycle Ack).
module mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        We0,
    input  logic [19:0] Addr0,
    input  logic [15:0] Wdata0,
    input  logic        Req1,
    input  logic        We1,
    input  logic [19:0] Addr1,
    input  logic [15:0] Wdata1,
    output logic        Ack0,
    output logic        Ack1,
    output logic [15:0] Rdata,
    output logic        Busy,
    output logic [19:0] Mem_ADDR,
    output logic [15:0] Data_to_SRAM,
    output logic        Mem_Drive,
    input  logic [15:0] Data_from_SRAM,
    output logic        Mem_CE,
    output logic        Mem_UB,
    output logic        Mem_LB,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(ACCESS_CYCLES - 1);

    state_e      state;
    logic        prio;
    logic [3:0]  cnt;
    logic        grant1;
    logic        we_lat;

    logic        pick1;
    logic        sel_we;
    logic [19:0] sel_addr;
    logic [15:0] sel_wdata;

    // Requester 1 wins when alone, or when both request and the pointer names it.
    always_comb begin
        pick1     = Req1 & (~Req0 | prio);
        sel_we    = pick1 ? We1 : We0;
        sel_addr  = pick1 ? Addr1 : Addr0;
        sel_wdata = pick1 ? Wdata1 : Wdata0;
    end

    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= StIdle;
            prio         <= 1'b0;
            cnt          <= 4'd0;
            grant1       <= 1'b0;
            we_lat       <= 1'b0;
            Ack0         <= 1'b0;
            Ack1         <= 1'b0;
            Busy         <= 1'b0;
            Rdata        <= 16'd0;
            Mem_ADDR     <= 20'd0;
            Data_to_SRAM <= 16'd0;
            Mem_Drive    <= 1'b0;
            Mem_CE       <= 1'b1;
            Mem_OE       <= 1'b1;
            Mem_WE       <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    if (Req0 | Req1) begin
                        state        <= StAccess;
                        grant1       <= pick1;
                        prio         <= ~pick1;
                        we_lat       <= sel_we;
                        Mem_ADDR     <= sel_addr;
                        Data_to_SRAM <= sel_wdata;
                        cnt          <= CntLoad;
                        Busy         <= 1'b1;
                        Mem_CE       <= 1'b0;
                        // Exactly one strobe goes low, chosen by direction.
                        Mem_OE       <= sel_we;
                        Mem_WE       <= ~sel_we;
                        Mem_Drive    <= sel_we;
                    end
                end
                StAccess: begin
                    if (cnt == 4'd0) begin
                        state  <= StDone;
                        Mem_OE <= 1'b1;
                        Mem_WE <= 1'b1;
                        Ack0   <= ~grant1;
                        Ack1   <= grant1;
                        if (!we_lat) begin
                            Rdata <= Data_from_SRAM;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StDone: begin
                    // Drive was kept through DONE to give write data hold past WE rising.
                    state     <= StIdle;
                    Ack0      <= 1'b0;
                    Ack1      <= 1'b0;
                    Busy      <= 1'b0;
                    Mem_CE    <= 1'b1;
                    Mem_Drive <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model feeding a scoreboard,
// directed scenarios, randomized two-requester traffic, and latency checks at ACCESS_CYCLES 1/15.
module tb_mem_arbiter;

    localparam int AC = 2;

    logic        Clk, Reset;
    logic        Req0, We0, Req1, We1;
    logic [19:0] Addr0, Addr1;
    logic [15:0] Wdata0, Wdata1, Data_from_SRAM;

    logic        Ack0, Ack1, Busy, Mem_Drive, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [15:0] Rdata, Data_to_SRAM;
    logic [19:0] Mem_ADDR;

    logic        s1_ack0, s1_ack1, s1_busy, s1_drive, s1_ce, s1_ub, s1_lb, s1_oe, s1_we;
    logic [15:0] s1_rdata, s1_dout;
    logic [19:0] s1_addr;
    logic        s15_ack0, s15_ack1, s15_busy, s15_drive, s15_ce, s15_ub, s15_lb, s15_oe, s15_we;
    logic [15:0] s15_rdata, s15_dout;
    logic [19:0] s15_addr;

    mem_arbiter #(.ACCESS_CYCLES(AC)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .Wdata0(Wdata0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .Wdata1(Wdata1),
        .Ack0(Ack0), .Ack1(Ack1), .Rdata(Rdata), .Busy(Busy),
        .Mem_ADDR(Mem_ADDR), .Data_to_SRAM(Data_to_SRAM), .Mem_Drive(Mem_Drive),
        .Data_from_SRAM(Data_from_SRAM),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    mem_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .Wdata0(Wdata0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .Wdata1(Wdata1),
        .Ack0(s1_ack0), .Ack1(s1_ack1), .Rdata(s1_rdata), .Busy(s1_busy),
        .Mem_ADDR(s1_addr), .Data_to_SRAM(s1_dout), .Mem_Drive(s1_drive),
        .Data_from_SRAM(Data_from_SRAM),
        .Mem_CE(s1_ce), .Mem_UB(s1_ub), .Mem_LB(s1_lb), .Mem_OE(s1_oe), .Mem_WE(s1_we)
    );

    mem_arbiter #(.ACCESS_CYCLES(15)) u_dut15 (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .Wdata0(Wdata0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .Wdata1(Wdata1),
        .Ack0(s15_ack0), .Ack1(s15_ack1), .Rdata(s15_rdata), .Busy(s15_busy),
        .Mem_ADDR(s15_addr), .Data_to_SRAM(s15_dout), .Mem_Drive(s15_drive),
        .Data_from_SRAM(Data_from_SRAM),
        .Mem_CE(s15_ce), .Mem_UB(s15_ub), .Mem_LB(s15_lb), .Mem_OE(s15_oe), .Mem_WE(s15_we)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        int          who;
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ack_edge;
    } txn_t;

    txn_t        sb[$];
    logic [15:0] sram    [logic [19:0]];
    logic [15:0] ref_mem [logic [19:0]];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          edge_cnt = 0;
    int          next_sample = 0;
    int          m_prio = 0;
    logic [15:0] last_rd = 16'd0;
    bit          chk_en = 1'b0;

    function automatic logic [15:0] init_val(input logic [19:0] a);
        return a[15:0] ^ 16'hc3a5 ^ {a[3:0], 12'h000};
    endfunction

    function automatic logic [15:0] sram_rd(input logic [19:0] a);
        return sram.exists(a) ? sram[a] : init_val(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // SRAM behaviour: data valid only while OE is low; writes land on WE rising.
    initial begin
        Data_from_SRAM = 16'd0;
        forever begin
            @(negedge Clk);
            Data_from_SRAM = (Mem_OE === 1'b0) ? sram_rd(Mem_ADDR) : 16'h0bad;
        end
    end

    initial forever begin
        @(posedge Mem_WE);
        if (Mem_CE === 1'b0 && Mem_Drive === 1'b1) sram[Mem_ADDR] = Data_to_SRAM;
    end

    // Reference model: one grant per busy window of AC+2 edges, round-robin on contention.
    initial begin
        txn_t t;
        int   g;
        forever begin
            @(posedge Clk);
            edge_cnt++;
            if (Reset) begin
                sb.delete();
                m_prio      = 0;
                last_rd     = 16'd0;
                next_sample = edge_cnt + 1;
            end else if (edge_cnt >= next_sample && (Req0 || Req1)) begin
                g       = (Req0 && Req1) ? m_prio : (Req1 ? 1 : 0);
                t.who   = g;
                t.we    = (g == 1) ? We1 : We0;
                t.addr  = (g == 1) ? Addr1 : Addr0;
                t.wdata = (g == 1) ? Wdata1 : Wdata0;
                if (t.we) ref_mem[t.addr] = t.wdata;
                else last_rd = ref_rd(t.addr);
                t.rdata     = last_rd;
                t.ack_edge  = edge_cnt + AC;
                sb.push_back(t);
                m_prio      = 1 - g;
                next_sample = edge_cnt + AC + 2;
            end
        end
    end

    // Monitor: compares every cycle against the outstanding transaction, if any.
    initial begin
        txn_t cur;
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                check("ack_overlap", 32'(Ack0 & Ack1), 0);
                check("oe_we_both_low", 32'(!Mem_OE && !Mem_WE), 0);
                check("ub_lb", {Mem_UB, Mem_LB}, 0);
                if (sb.size() == 0) begin
                    check("idle_acks", {Ack0, Ack1}, 0);
                    check("idle_busy", Busy, 0);
                    check("idle_ctrl", {Mem_CE, Mem_OE, Mem_WE, Mem_Drive}, 4'b1110);
                end else begin
                    cur = sb[0];
                    if (edge_cnt < cur.ack_edge) begin
                        check("acc_acks", {Ack0, Ack1}, 0);
                        check("acc_busy", Busy, 1);
                        check("acc_ctrl", {Mem_CE, Mem_OE, Mem_WE, Mem_Drive},
                              {1'b0, cur.we, !cur.we, cur.we});
                        check("acc_addr", Mem_ADDR, cur.addr);
                        if (cur.we) check("acc_wdata", Data_to_SRAM, cur.wdata);
                    end else begin
                        check("done_ack0", Ack0, 32'(cur.who == 0));
                        check("done_ack1", Ack1, 32'(cur.who == 1));
                        check("done_busy", Busy, 1);
                        check("done_ctrl", {Mem_CE, Mem_OE, Mem_WE, Mem_Drive},
                              {3'b011, cur.we});
                        check("done_addr", Mem_ADDR, cur.addr);
                        check("done_rdata", Rdata, cur.rdata);
                        cur = sb.pop_front();
                    end
                end
            end
        end
    end

    task automatic drop_req(input int r);
        if (r == 0) Req0 = 1'b0;
        else Req1 = 1'b0;
    endtask

    // One directed access on the AC=2 instance; reports Ack index (cycles after the
    // sampling edge), strobe width, Drive width and Ack count.
    task automatic do_access(input int r, input bit we, input logic [19:0] addr,
                             input logic [15:0] wd, input int drop_at,
                             output int ack_idx, output int strobe, output int drv,
                             output int acks);
        @(negedge Clk);
        if (r == 0) begin Req0 = 1'b1; We0 = we; Addr0 = addr; Wdata0 = wd; end
        else begin Req1 = 1'b1; We1 = we; Addr1 = addr; Wdata1 = wd; end
        ack_idx = -1; strobe = 0; drv = 0; acks = 0;
        for (int i = 0; i < AC + 6; i++) begin
            @(negedge Clk);
            if (we ? !Mem_WE : !Mem_OE) strobe++;
            if (Mem_Drive) drv++;
            if ((r == 0) ? Ack0 : Ack1) begin
                acks++;
                if (ack_idx < 0) ack_idx = i;
                drop_req(r);
            end
            if (i == drop_at) drop_req(r);
        end
        drop_req(r);
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        int ai, st, dv, na;
        int nacks;
        int who_seq[4];
        int i1, i15, st1, st15, n1, n15;

        Reset = 1'b1;
        Req0 = 1'b0; We0 = 1'b0; Addr0 = '0; Wdata0 = '0;
        Req1 = 1'b0; We1 = 1'b0; Addr1 = '0; Wdata1 = '0;
        @(negedge Clk);
        chk_en = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_rdata", Rdata, 0);
        check("rst_addr", Mem_ADDR, 0);
        check("rst_dout", Data_to_SRAM, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Read from requester 0.
        sram[20'h00123]    = 16'hBEEF;
        ref_mem[20'h00123] = 16'hBEEF;
        do_access(0, 1'b0, 20'h00123, 16'h0000, -1, ai, st, dv, na);
        check("rd_ack_idx", ai, AC);
        check("rd_oe_width", st, AC);
        check("rd_drive", dv, 0);
        check("rd_acks", na, 1);
        check("rd_rdata", Rdata, 16'hBEEF);

        // Write from requester 1.
        do_access(1, 1'b1, 20'h00040, 16'h1234, -1, ai, st, dv, na);
        check("wr_ack_idx", ai, AC);
        check("wr_we_width", st, AC);
        check("wr_drive", dv, AC + 1);
        check("wr_acks", na, 1);
        check("wr_rdata_kept", Rdata, 16'hBEEF);
        check("wr_sram", sram_rd(20'h00040), 16'h1234);

        // Req0 dropped in the first ACCESS cycle.
        do_access(0, 1'b0, 20'h00123, 16'h0000, 0, ai, st, dv, na);
        check("drop_ack_idx", ai, AC);
        check("drop_acks", na, 1);
        check("drop_oe_width", st, AC);

        // Reset during the first ACCESS cycle of a write.
        @(negedge Clk);
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 20'h00777; Wdata1 = 16'hABCD;
        @(negedge Clk);
        check("abort_pre_we", Mem_WE, 0);
        Reset = 1'b1; Req1 = 1'b0;
        @(negedge Clk);
        check("abort_we", Mem_WE, 1);
        check("abort_drive", Mem_Drive, 0);
        check("abort_acks", {Ack0, Ack1}, 0);
        check("abort_busy", Busy, 0);
        check("abort_rdata", Rdata, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Contention with both requests held: grants must alternate from requester 0.
        @(negedge Clk);
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 20'h00123;
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 20'h00040;
        nacks = 0;
        for (int k = 0; k < 4; k++) who_seq[k] = -1;
        for (int i = 0; i < 40 && nacks < 4; i++) begin
            @(negedge Clk);
            if (Ack0 || Ack1) begin
                who_seq[nacks] = Ack1 ? 1 : 0;
                nacks++;
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
        check("cont_count", nacks, 4);
        for (int k = 0; k < 4; k++) check("cont_order", who_seq[k], k % 2);

        // Latency and strobe width at ACCESS_CYCLES = 1 and 15 (read, then write).
        pulse_reset();
        for (int p = 0; p < 2; p++) begin
            @(negedge Clk);
            Req0 = 1'b1; We0 = p[0]; Addr0 = 20'h00005; Wdata0 = 16'h5A5A;
            i1 = -1; i15 = -1; st1 = 0; st15 = 0; n1 = 0; n15 = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge Clk);
                if (i == 0) Req0 = 1'b0;
                if (p == 1 ? !s1_we : !s1_oe) st1++;
                if (p == 1 ? !s15_we : !s15_oe) st15++;
                if (s1_ack0) begin n1++; if (i1 < 0) i1 = i; end
                if (s15_ack0) begin n15++; if (i15 < 0) i15 = i; end
            end
            check("ac1_ack_idx", i1, 1);
            check("ac1_strobe", st1, 1);
            check("ac1_acks", n1, 1);
            check("ac15_ack_idx", i15, 15);
            check("ac15_strobe", st15, 15);
            check("ac15_acks", n15, 1);
        end

        // Randomized traffic: requests held until Ack, sometimes dropped once granted.
        for (int c = 0; c < 1500; c++) begin
            @(negedge Clk);
            if (Req0) begin
                if (Ack0 || (sb.size() > 0 && sb[0].who == 0 && $urandom_range(3) == 0))
                    Req0 = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                Req0 = 1'b1; We0 = $urandom_range(1) == 1;
                Addr0 = 20'($urandom_range(15)); Wdata0 = 16'($urandom);
            end
            if (Req1) begin
                if (Ack1 || (sb.size() > 0 && sb[0].who == 1 && $urandom_range(3) == 0))
                    Req1 = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                Req1 = 1'b1; We1 = $urandom_range(1) == 1;
                Addr1 = 20'($urandom_range(15)); Wdata1 = 16'($urandom);
            end
        end
        @(negedge Clk);
        Req0 = 1'b0; Req1 = 1'b0;
        repeat (AC + 4) @(negedge Clk);
        check("drain_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2: number of cycles the SRAM strobe is held active per access; legal range 1..15.
REQ-002 Clk  in  1  system clock; all state changes on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Req0  in  1  requester 0 (CPU/ISDU side) access request; held until Ack0.
REQ-005 We0  in  1  requester 0 direction: 1 = write, 0 = read.
REQ-006 Addr0  in  20  requester 0 word address.
REQ-007 Wdata0  in  16  requester 0 write data.
REQ-008 Req1, We1, Addr1, Wdata1  in  1/1/20/16  requester 1 (I/O or debug port), same meaning as requester 0.
REQ-009 Ack0, Ack1  out  1 each  one-cycle completion pulse for the granted requester.
REQ-010 Rdata  out  16  registered read data; valid in the Ack cycle of a read; held until the next read completes.
REQ-011 Busy  out  1  1 whenever the state is not IDLE.
REQ-012 Mem_ADDR  out  20  SRAM address.
REQ-013 Data_to_SRAM  out  16  SRAM write data; Mem_Drive  out  1  tri-state enable for the SRAM data bus.
REQ-014 Data_from_SRAM  in  16  SRAM read data.
REQ-015 Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM controls, active-low.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-017 IDLE: if any Req is sampled high, latch the winner, its address, its write data and its direction; go to ACCESS and load the cycle counter with ACCESS_CYCLES-1. Otherwise stay in IDLE.
REQ-018 Arbitration: a single requester is always granted; if both request, grant the requester named by priority pointer Prio.
REQ-019 After every grant, Prio SHALL point to the non-granted requester (round-robin).
REQ-020 ACCESS: decrement the counter each cycle; when the counter is 0, go to DONE. ACCESS therefore lasts exactly ACCESS_CYCLES cycles.
REQ-021 DONE: pulse Ack of the granted requester for exactly one cycle, then go to IDLE.
REQ-022 Latency: Req sampled at edge k puts Ack high in cycle k+ACCESS_CYCLES+1, provided the arbiter is in IDLE at edge k.
REQ-023 Read: Mem_OE = 0 during all ACCESS cycles. Rdata captures Data_from_SRAM at the edge leaving the last ACCESS cycle.
REQ-024 Write: Mem_WE = 0 during all ACCESS cycles. Mem_Drive = 1 in ACCESS and DONE, so data is held one cycle past the WE rising edge. Rdata is unchanged by a write.
REQ-025 Mem_OE and Mem_WE SHALL never be low in the same cycle. Both are 1 in IDLE and DONE.
REQ-026 Mem_CE = 0 in ACCESS and DONE, 1 in IDLE. Mem_UB = Mem_LB = 0 constant.
REQ-027 Mem_ADDR and Data_to_SRAM come from the latched values and stay stable from the first ACCESS cycle through DONE, whatever the requester inputs do.
REQ-028 Req sampled in IDLE right after DONE is a new request. A requester must drop Req in the cycle after Ack, or it is granted again, subject to REQ-018/019.
REQ-029 If Req is deasserted mid-access, the access still completes and Ack still pulses.
REQ-030 Requests arriving while Busy are not lost; they are evaluated at the next IDLE cycle.
REQ-031 Ack0 and Ack1 SHALL never be high in the same cycle.

Reset
REQ-032 Reset SHALL force: state IDLE, Prio = requester 0, counter 0, Ack0 = Ack1 = 0, Busy = 0, Rdata = 0, Mem_ADDR = 0, Data_to_SRAM = 0, Mem_Drive = 0, Mem_CE = Mem_OE = Mem_WE = 1.
REQ-033 Reset asserted mid-access SHALL abort the access. The next cycle shows the REQ-032 values, with no Ack and no write strobe.

Verification
REQ-034 Read: after reset, Req0 = 1, We0 = 0, Addr0 = 0x00123, SRAM returns 0xBEEF. Expect Mem_OE low in cycles 1-2, Ack0 high in cycle 3, Rdata = 0xBEEF.
REQ-035 Write: Req1 = 1, We1 = 1, Addr1 = 0x00040, Wdata1 = 0x1234. Expect Mem_WE low 2 cycles, Mem_Drive high 3 cycles, Mem_ADDR = 0x00040, Ack1 pulse, Rdata unchanged.
REQ-036 Contention: Req0 and Req1 held high continuously. Expect grants in the order 0, 1, 0, 1, with each Ack one cycle long and never overlapping.
REQ-037 Reset in the first ACCESS cycle of a write. Expect Mem_WE = 1 and Mem_Drive = 0 next cycle, no Ack, Busy = 0.
REQ-038 Req0 dropped in the first ACCESS cycle. Expect Ack0 still pulses in cycle 3 and no second grant follows.
REQ-039 ACCESS_CYCLES = 1 and = 15. Expect Ack at k+2 and k+16 respectively, with the strobe width equal to ACCESS_CYCLES.
